reg_writeback_ctrl: RTL
=======================

# reg_writeback_ctrl

Write-side controller for the MIPS register file write port. It merges single-cycle ALU results with buffered load returns and drives reg_write_enable, reg_dest_sel, field_reg_dest and reg_input_data from registered outputs on posedge clk. The register file samples these on the following negedge. It also keeps a pending-load scoreboard that decode uses to stall on load-use and WAW hazards.

## Interface
- LD_DEPTH, default 2: load-return FIFO depth; power of two, minimum 2.
- STARVE_LIMIT, default 4: consecutive ALU-won cycles tolerated before the guard forces a load write (guard build only).
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low.
- alu_valid  in  1  ALU result present this cycle; there is no ALU backpressure except alu_stall.
- alu_dest  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  ALU must hold its result (guard build only; tied 0 otherwise).
- ld_issue  in  1  load issued this cycle; marks ld_issue_dest pending.
- ld_issue_dest  in  5  destination of the issued load.
- ld_valid  in  1  load data return valid.
- ld_ready  out  1  FIFO can accept; equals (count < LD_DEPTH), registered.
- ld_dest  in  5  returned load destination.
- ld_data  in  32  returned load data.
- reg_write_enable  out  1  to register file.
- reg_dest_sel  out  1  to register file; 1 when out of reset.
- field_reg_dest  out  5  to register file.
- reg_input_data  out  32  to register file.
- busy_vector  out  32  bit r = 1 while a load to r is outstanding; bit 0 is always 0.
- waw_err  out  1  sticky; set when an ALU write targets a busy register.

## Operation
- Reset (reset=0 at posedge): FIFO emptied, busy_vector=0, waw_err=0, starve counter=0. Outputs: reg_write_enable=0, reg_dest_sel=0, field_reg_dest=0, reg_input_data=0, ld_ready=0, alu_stall=0. On the first edge after reset deasserts, ld_ready=1 and reg_dest_sel=1.
- Load push: ld_valid & ld_ready at posedge writes {ld_dest, ld_data} to the FIFO tail.
- Port arbitration, evaluated each posedge:
  - alu_valid & !alu_stall: ALU wins the port.
  - else if FIFO is non-empty: pop the head.
  - else: idle, reg_write_enable=0.
- Winner's dest/data are registered to field_reg_dest/reg_input_data. reg_write_enable=1 unless dest==0; a $0 write is dropped but still pops.
- Scoreboard:
  - ld_issue with a non-zero dest sets busy[dest].
  - A load pop clears busy[dest].
  - Same-edge set and clear of the same register: set wins.
  - An ALU win with busy[alu_dest]=1 sets waw_err; the write still proceeds.
- Push and pop on the same edge are legal. Count is unchanged. ld_ready reflects the pre-edge count, with no same-cycle pass-through.
- Pointers wrap modulo LD_DEPTH. count has log2(LD_DEPTH)+1 bits.

## Timing
- ALU: alu_valid at edge N produces reg_write_enable high for the cycle after N. The register file writes at that cycle's negedge.
- Load: push at edge N gives an earliest pop at edge N+1, with the port outputs valid after N+1. Minimum return-to-write latency is 2 edges.
- busy_vector updates at the edge of ld_issue or of the pop. Decode sees the bit set in the cycle after issue.
- ld_ready drops in the cycle after the FIFO reaches full. The sender must not assert ld_valid while ld_ready=0; such a beat is ignored.
- Reset mid-operation discards queued loads and clears busy_vector at that edge. No write is issued in the reset cycle.

## Configuration
- WB_STARVE_GUARD_EN defined:
  - Starve counter increments on each edge where the ALU wins while the FIFO is non-empty. It clears on any pop or when the FIFO is empty.
  - When counter == STARVE_LIMIT, alu_stall=1 combinationally, the FIFO head wins that edge, and the counter clears.
- WB_STARVE_GUARD_EN undefined: strict ALU priority, alu_stall tied 0, no counter logic.

## Test plan
- Reset then idle: with reset=0 for 2 edges, all outputs are 0. After release, ld_ready=1, reg_dest_sel=1, reg_write_enable=0.
- ALU write: alu_valid, dest=5, data=0xDEADBEEF at edge N → after N: reg_write_enable=1, field_reg_dest=5, reg_input_data=0xDEADBEEF. A dest=0 write leaves reg_write_enable=0.
- Load lifecycle: ld_issue dest=9 → busy_vector=0x200. Return ld_dest=9, data=0x1234 with no ALU traffic → write visible 2 edges later, and busy_vector=0 after the pop edge.
- FIFO full/backpressure:
  - With alu_valid held high, push 2 loads → ld_ready=0. A third ld_valid is ignored.
  - Drop alu_valid → both loads write in order on consecutive cycles, then ld_ready=1.
- Hazards: ld_issue dest=3 followed by an ALU write to 3 → waw_err=1, sticky until reset. Same-edge ld_issue dest=3 and pop of dest 3 → busy[3]=1.
- Guard (WB_STARVE_GUARD_EN, STARVE_LIMIT=4): alu_valid continuous with 1 queued load → alu_stall=1 on the 5th edge and the load writes. Without the macro, the load waits until alu_valid drops.

Source files
------------

// File: rtl/reg_writeback_ctrl.sv
// Register file write-port controller: merges ALU results with buffered
// load returns and tracks pending loads. Optional guard: WB_STARVE_GUARD_EN.
module reg_writeback_ctrl #(
    parameter int unsigned LD_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_dest,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_dest,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_dest,
    input  logic [31:0] ld_data,
    output logic        reg_write_enable,
    output logic        reg_dest_sel,
    output logic [4:0]  field_reg_dest,
    output logic [31:0] reg_input_data,
    output logic [31:0] busy_vector,
    output logic        waw_err
);

    localparam int unsigned AW = $clog2(LD_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(LD_DEPTH);

    logic [36:0]   mem_q [LD_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ld_ready_q, ld_ready_d;
    logic          we_q, we_d;
    logic          sel_q;
    logic [4:0]    dest_q, dest_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   busy_q, busy_d;
    logic          waw_q, waw_d;

    logic          stall;
    logic          alu_win;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [4:0]    head_dest;
    logic [31:0]   head_data;

    assign fifo_empty = (count_q == '0);
    assign alu_win    = alu_valid & ~stall;
    assign pop        = ~alu_win & ~fifo_empty;
    assign push       = ld_valid & ld_ready_q;
    assign head_dest  = mem_q[rd_ptr_q][36:32];
    assign head_data  = mem_q[rd_ptr_q][31:0];

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign stall = (starve_q == SW'(STARVE_LIMIT));

    // Count ALU wins that leave a queued load waiting
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_win) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Starve counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign stall = 1'b0;
`endif

    assign alu_stall = stall;

    // Next-state for FIFO, write port, scoreboard
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        we_d     = 1'b0;
        dest_d   = dest_q;
        data_d   = data_q;
        busy_d   = busy_q;
        waw_d    = waw_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        ld_ready_d = (count_d < DEPTH_C);

        if (alu_win) begin
            we_d   = (alu_dest != 5'd0);
            dest_d = alu_dest;
            data_d = alu_data;
            if (busy_q[alu_dest]) waw_d = 1'b1;
        end else if (pop) begin
            we_d   = (head_dest != 5'd0);
            dest_d = head_dest;
            data_d = head_data;
        end

        // Clear first so a same-edge issue to the same register wins
        if (pop) busy_d[head_dest] = 1'b0;
        if (ld_issue && ld_issue_dest != 5'd0) busy_d[ld_issue_dest] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ld_ready_q <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 1'b0;
            dest_q     <= '0;
            data_q     <= '0;
            busy_q     <= '0;
            waw_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ld_ready_q <= ld_ready_d;
            we_q       <= we_d;
            sel_q      <= 1'b1;
            dest_q     <= dest_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            waw_q      <= waw_d;
        end
    end

    // Load-return storage; contents are don't-care once pointers reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {ld_dest, ld_data};
    end

    assign ld_ready         = ld_ready_q;
    assign reg_write_enable = we_q;
    assign reg_dest_sel     = sel_q;
    assign field_reg_dest   = dest_q;
    assign reg_input_data   = data_q;
    assign busy_vector      = busy_q;
    assign waw_err          = waw_q;

endmodule
